// File: rtl/turf_event_framer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : turf_event_framer_pkg
//  Brief    : Shared constants, FSM encoding and header check for the framer.
//  Revision : 1.0
// ============================================================================
package turf_event_framer_pkg;

    localparam int DATA_W = 32;
    localparam int STAT_W = 8;

    localparam logic [7:0]  EVT_MAGIC    = 8'hE5;
    localparam logic [7:0]  ST_BAD_MAGIC = 8'h81;
    localparam logic [7:0]  ST_BAD_LEN   = 8'h82;
    localparam logic [7:0]  ST_ABORT     = 8'h83;
    localparam logic [7:0]  ST_HDR_OK    = 8'h00;
    localparam logic [31:0] ABORT_WORD   = 32'hDEADDEAD;

    typedef enum logic [1:0] {
        S_HDR   = 2'd0,
        S_PAY   = 2'd1,
        S_ABORT = 2'd2
    } framer_state_e;

    // Returns ST_HDR_OK for a usable header, otherwise the error status byte.
    function automatic logic [7:0] hdr_check(input logic [7:0] magic,
                                             input logic [15:0] len,
                                             input int max_words);
        if (magic != EVT_MAGIC)
            return ST_BAD_MAGIC;
        if ((len == 16'd0) || (int'(len) > max_words))
            return ST_BAD_LEN;
        return ST_HDR_OK;
    endfunction

endpackage
`default_nettype wire

// File: rtl/turf_event_framer_if.sv
`default_nettype none
// ============================================================================
//  Module   : turf_event_framer_if
//  Brief    : Host write stream, AXIS event stream and status stream bundle.
//  Revision : 1.0
// ============================================================================
interface turf_event_framer_if;
    import turf_event_framer_pkg::*;

    logic [DATA_W-1:0] s_data;
    logic              s_wren;
    logic              s_full;
    logic              s_open;

    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;

    logic [STAT_W-1:0] st_tdata;
    logic              st_tvalid;
    logic              st_tready;

    modport master (
        input  s_data, s_wren, s_open, m_axis_tready, st_tready,
        output s_full, m_axis_tdata, m_axis_tvalid, m_axis_tlast, st_tdata, st_tvalid
    );

    modport slave (
        output s_data, s_wren, s_open, m_axis_tready, st_tready,
        input  s_full, m_axis_tdata, m_axis_tvalid, m_axis_tlast, st_tdata, st_tvalid
    );
endinterface
`default_nettype wire

// File: rtl/turf_event_framer_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : turf_sync_fifo
//  Brief    : First-word-fall-through synchronous FIFO with occupancy count.
//  Revision : 1.0
// ============================================================================
module turf_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // A pop in the same cycle frees the slot, so a write at full still lands.
    assign full    = (count == FULL_CNT);
    assign do_rd   = rd_en && (count != '0);
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_rd)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_wr) - CW'(do_rd);
        end
    end
endmodule
`default_nettype wire

// File: rtl/turf_event_framer.sv
`default_nettype none
// ============================================================================
//  Module   : turf_event_framer
//  Brief    : Frames host header+payload words into AXIS events with tlast and
//             emits one status byte per event or framing error.
//  Revision : 1.0
// ============================================================================
module turf_event_framer
    import turf_event_framer_pkg::*;
#(
    parameter int FIFO_DEPTH = 64,
    parameter int MAX_WORDS  = 1024,
    parameter int STAT_DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    turf_event_framer_if.master bus,
    output logic [15:0]         event_count,
    output logic [15:0]         err_count,
    output logic                st_overflow
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = $clog2(STAT_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_LEVEL = CW'(FIFO_DEPTH - 2);

    framer_state_e state;
    logic [15:0]   remaining;
    logic [6:0]    cur_tag;

    logic [31:0]   out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_good;
    logic [6:0]    out_tag;
    logic          s_full_r;

    logic [31:0]   in_word;
    logic          in_full;
    logic [CW-1:0] in_count;
    logic [CW-1:0] in_count_next;
    logic          in_empty;
    logic          in_push;
    logic          in_pop;
    logic          in_drop;
    logic [7:0]    hdr_code;

    logic [7:0]    st_word;
    logic          st_full;
    logic [SW-1:0] st_count;
    logic          st_valid;
    logic          st_push;
    logic          st_pop;
    logic [7:0]    st_push_data;

    logic          can_load;
    logic          pend_good;
    logic          good_accept;
    logic          load;
    logic          load_last;
    logic          load_good;
    logic [31:0]   load_data;
    logic          fsm_err;
    logic          fsm_st_push;
    logic [7:0]    fsm_st;
    logic [1:0]    err_inc;
    logic [16:0]   err_sum;

    turf_sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_in_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.s_wren),
        .wr_data (bus.s_data),
        .rd_en   (in_pop),
        .rd_data (in_word),
        .full    (in_full),
        .count   (in_count)
    );

    turf_sync_fifo #(.WIDTH(8), .DEPTH(STAT_DEPTH)) u_st_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (st_push),
        .wr_data (st_push_data),
        .rd_en   (st_pop),
        .rd_data (st_word),
        .full    (st_full),
        .count   (st_count)
    );

    assign in_empty      = (in_count == '0);
    assign in_push       = bus.s_wren && (!in_full || in_pop);
    assign in_drop       = bus.s_wren && in_full && !in_pop;
    assign in_count_next = in_count + CW'(in_push) - CW'(in_pop);
    assign hdr_code      = hdr_check(in_word[31:24], in_word[15:0], MAX_WORDS);

    assign can_load    = !out_valid || bus.m_axis_tready;
    assign pend_good   = out_valid && out_good;
    assign good_accept = out_valid && out_good && bus.m_axis_tready;

    // A completed event's status is pushed when its last beat is accepted; a bad
    // header waits while such a beat is pending so the two never share a push.
    always_comb begin
        in_pop      = 1'b0;
        load        = 1'b0;
        load_data   = '0;
        load_last   = 1'b0;
        load_good   = 1'b0;
        fsm_err     = 1'b0;
        fsm_st_push = 1'b0;
        fsm_st      = '0;
        case (state)
            S_HDR: begin
                if (!in_empty && can_load) begin
                    if (hdr_code == ST_HDR_OK) begin
                        in_pop    = 1'b1;
                        load      = 1'b1;
                        load_data = in_word;
                    end else if (!pend_good) begin
                        in_pop      = 1'b1;
                        fsm_err     = 1'b1;
                        fsm_st_push = 1'b1;
                        fsm_st      = hdr_code;
                    end
                end
            end
            S_PAY: begin
                if (!in_empty && can_load) begin
                    in_pop    = 1'b1;
                    load      = 1'b1;
                    load_data = in_word;
                    load_last = (remaining == 16'd1);
                    load_good = (remaining == 16'd1);
                end
            end
            S_ABORT: begin
                if (can_load) begin
                    load        = 1'b1;
                    load_data   = ABORT_WORD;
                    load_last   = 1'b1;
                    fsm_err     = 1'b1;
                    fsm_st_push = 1'b1;
                    fsm_st      = ST_ABORT;
                end
            end
            default: ;
        endcase
    end

    assign st_valid     = (st_count != '0);
    assign st_pop       = st_valid && bus.st_tready;
    assign st_push      = good_accept || fsm_st_push;
    assign st_push_data = good_accept ? {1'b0, out_tag} : fsm_st;
    assign err_inc      = {1'b0, in_drop} + {1'b0, fsm_err};
    assign err_sum      = {1'b0, err_count} + {15'd0, err_inc};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_HDR;
            remaining   <= '0;
            cur_tag     <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_good    <= 1'b0;
            out_tag     <= '0;
            s_full_r    <= 1'b0;
            event_count <= '0;
            err_count   <= '0;
            st_overflow <= 1'b0;
        end else begin
            s_full_r <= (in_count_next >= FULL_LEVEL);

            if (out_valid && bus.m_axis_tready)
                out_valid <= 1'b0;
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= load_data;
                out_last  <= load_last;
                out_good  <= load_good;
                out_tag   <= cur_tag;
            end

            case (state)
                S_HDR: begin
                    if (load) begin
                        state     <= S_PAY;
                        remaining <= in_word[15:0];
                        cur_tag   <= in_word[22:16];
                    end
                end
                S_PAY: begin
                    if (in_pop) begin
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1)
                            state <= S_HDR;
                    end else if (in_empty && !bus.s_open) begin
                        state <= S_ABORT;
                    end
                end
                S_ABORT: begin
                    if (load)
                        state <= S_HDR;
                end
                default: state <= S_HDR;
            endcase

            if (good_accept)
                event_count <= event_count + 16'd1;
            err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
            if (st_push && st_full && !st_pop)
                st_overflow <= 1'b1;
        end
    end

    assign bus.s_full        = s_full_r;
    assign bus.m_axis_tdata  = out_data;
    assign bus.m_axis_tvalid = out_valid;
    assign bus.m_axis_tlast  = out_last;
    assign bus.st_tdata      = st_word;
    assign bus.st_tvalid     = st_valid;
endmodule
`default_nettype wire

// File: tb/tb_turf_event_framer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_turf_event_framer
//  Brief    : Randomized and directed bench with an event-level reference model.
//  Revision : 1.0
// ============================================================================
module tb_turf_event_framer;
    import turf_event_framer_pkg::*;

    localparam int FIFO_DEPTH = 64;
    localparam int MAX_WORDS  = 1024;
    localparam int STAT_DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] event_count;
    logic [15:0] err_count;
    logic        st_overflow;

    turf_event_framer_if bus ();

    turf_event_framer #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .MAX_WORDS  (MAX_WORDS),
        .STAT_DEPTH (STAT_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.master),
        .event_count (event_count),
        .err_count   (err_count),
        .st_overflow (st_overflow)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Event-level model: parses the accepted word sequence into expected beats and statuses.
    logic [32:0] exp_beats[$];
    logic [7:0]  exp_st[$];
    int          m_evt = 0;
    int          m_err = 0;
    bit          m_ovf = 1'b0;
    bit          m_in_evt = 1'b0;
    int          m_rem = 0;
    logic [7:0]  m_tag = 8'h00;
    bit          st_cap = 1'b0;

    function automatic void push_st(input logic [7:0] b);
        if (st_cap && exp_st.size() >= STAT_DEPTH)
            m_ovf = 1'b1;
        else
            exp_st.push_back(b);
    endfunction

    function automatic void model_word(input logic [31:0] w);
        int len;
        len = int'(w[15:0]);
        if (!m_in_evt) begin
            if (w[31:24] != 8'hE5) begin
                m_err++;
                push_st(8'h81);
            end else if (len == 0 || len > MAX_WORDS) begin
                m_err++;
                push_st(8'h82);
            end else begin
                exp_beats.push_back({1'b0, w});
                m_in_evt = 1'b1;
                m_rem    = len;
                m_tag    = w[23:16];
            end
        end else begin
            m_rem--;
            exp_beats.push_back({m_rem == 0, w});
            if (m_rem == 0) begin
                m_in_evt = 1'b0;
                m_evt++;
                push_st({1'b0, m_tag[6:0]});
            end
        end
    endfunction

    function automatic void model_abort();
        if (m_in_evt) begin
            exp_beats.push_back({1'b1, 32'hDEADDEAD});
            m_err++;
            push_st(8'h83);
            m_in_evt = 1'b0;
        end
    endfunction

    function automatic void model_reset();
        exp_beats.delete();
        exp_st.delete();
        m_evt    = 0;
        m_err    = 0;
        m_ovf    = 1'b0;
        m_in_evt = 1'b0;
    endfunction

    int rdy_mode    = 1;
    int st_rdy_mode = 1;

    initial begin
        bus.m_axis_tready = 1'b0;
        bus.st_tready     = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.m_axis_tready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode != 0);
            bus.st_tready     = (st_rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (st_rdy_mode != 0);
        end
    end

    // Monitor samples at negedge: a handshake seen here completes on the next posedge.
    initial begin
        logic [32:0] hold_beat;
        logic [32:0] e;
        logic [7:0]  s;
        bit          hold_pend;
        hold_pend = 1'b0;
        hold_beat = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_pend = 1'b0;
            end else begin
                if (hold_pend)
                    check("axis_hold", {bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata},
                          {1'b1, hold_beat});
                hold_pend = bus.m_axis_tvalid && !bus.m_axis_tready;
                hold_beat = {bus.m_axis_tlast, bus.m_axis_tdata};
                if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                    check("axis_expected", bus.m_axis_tvalid, exp_beats.size() != 0);
                    if (exp_beats.size() != 0) begin
                        e = exp_beats.pop_front();
                        check("axis_beat", {bus.m_axis_tlast, bus.m_axis_tdata}, e);
                    end
                end
                if (bus.st_tvalid && bus.st_tready) begin
                    check("st_expected", bus.st_tvalid, exp_st.size() != 0);
                    if (exp_st.size() != 0) begin
                        s = exp_st.pop_front();
                        check("st_byte", bus.st_tdata, s);
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic put(input logic [31:0] w);
        int guard;
        guard = 0;
        while (bus.s_full) begin
            cyc(1);
            guard++;
            if (guard > 4000) begin
                vectors++;
                miscompares++;
                $display("FAIL put_timeout: s_full got 1 expected 0");
                $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
                $fatal(1, "input stream stalled");
            end
        end
        bus.s_data = w;
        bus.s_wren = 1'b1;
        model_word(w);
        cyc(1);
        bus.s_wren = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_beats.size() != 0 || exp_st.size() != 0) && n < 5000) begin
            cyc(1);
            n++;
        end
        check({tag, "_drain"}, exp_beats.size() + exp_st.size(), 0);
        cyc(4);
        check({tag, "_evt"}, event_count, 16'(m_evt));
        check({tag, "_err"}, err_count, 16'(m_err));
        check({tag, "_ovf"}, st_overflow, m_ovf);
    endtask

    initial begin
        int   written;
        bit   seen;
        int   r;
        int   len;
        logic [7:0] mg;

        rst        = 1'b1;
        bus.s_data = '0;
        bus.s_wren = 1'b0;
        bus.s_open = 1'b1;
        cyc(3);
        check("rst_s_full", bus.s_full, 0);
        check("rst_tvalid", bus.m_axis_tvalid, 0);
        check("rst_tlast",  bus.m_axis_tlast, 0);
        check("rst_tdata",  bus.m_axis_tdata, 0);
        check("rst_st_tvalid", bus.st_tvalid, 0);
        check("rst_evt", event_count, 0);
        check("rst_err", err_count, 0);
        check("rst_ovf", st_overflow, 0);
        rst = 1'b0;
        cyc(2);

        // Basic event
        put(32'hE507_0003); put(32'h0000_000A); put(32'h0000_000B); put(32'h0000_000C);
        drain("t1");
        check("t1_evt_count", event_count, 16'd1);

        // Bad magic then resync
        put(32'h1200_0002); put(32'hE501_0001); put(32'h1234_5678);
        drain("t2");

        // Length boundaries: 0 and MAX+1 rejected, MAX accepted
        put(32'hE500_0000); put({16'hE500, 16'(MAX_WORDS + 1)});
        drain("t3");
        put({16'hE50B, 16'(MAX_WORDS)});
        for (int i = 0; i < MAX_WORDS; i++) put(32'hB000_0000 + i);
        drain("t3max");

        // Backpressure: header parks in the output stage, FIFO fills to the threshold
        rdy_mode = 0;
        cyc(2);
        seen    = 1'b0;
        put(32'hE504_0045);
        written = 1;
        for (int i = 0; i < 69; i++) begin
            if (!seen && bus.s_full) begin
                seen = 1'b1;
                check("sfull_level", written, 63);
                rdy_mode = 1;
            end
            put(32'hA000_0000 + i);
            written++;
        end
        check("sfull_seen", seen, 1);
        drain("t4");

        // Abort on file close mid-payload
        put(32'hE505_0004); put(32'h1111_1111); put(32'h2222_2222);
        cyc(8);
        bus.s_open = 1'b0;
        model_abort();
        cyc(10);
        bus.s_open = 1'b1;
        drain("t5");

        // Status FIFO overflow with the status reader stalled
        st_rdy_mode = 0;
        st_cap      = 1'b1;
        cyc(2);
        for (int i = 0; i < STAT_DEPTH + 1; i++) put(32'h0000_0000);
        cyc(10);
        check("ovf_sticky", st_overflow, m_ovf);
        st_cap      = 1'b0;
        st_rdy_mode = 1;
        drain("ovf");

        // Reset mid-payload
        rdy_mode = 0;
        cyc(2);
        put(32'hE509_0005); put(32'h0000_0001); put(32'h0000_0002);
        cyc(4);
        check("pre_rst_tvalid", bus.m_axis_tvalid, 1);
        rst = 1'b1;
        cyc(1);
        check("t6_tvalid", bus.m_axis_tvalid, 0);
        check("t6_evt", event_count, 0);
        check("t6_err", err_count, 0);
        check("t6_ovf", st_overflow, 0);
        rst = 1'b0;
        model_reset();
        rdy_mode = 1;
        cyc(2);
        put(32'hE50A_0002); put(32'hCAFE_0001); put(32'hCAFE_0002);
        drain("t6");

        // Randomized traffic with random AXIS backpressure
        rdy_mode = 2;
        for (int ev = 0; ev < 80; ev++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                mg = 8'($urandom_range(0, 255));
                if (mg == 8'hE5) mg = 8'h5E;
                put({mg, 24'($urandom)});
            end else if (r == 1) begin
                if ($urandom_range(0, 1) == 1)
                    put({8'hE5, 8'($urandom), 16'd0});
                else
                    put({8'hE5, 8'($urandom), 16'(MAX_WORDS + 1 + $urandom_range(0, 100))});
            end else begin
                len = $urandom_range(1, 6);
                put({8'hE5, 8'($urandom), 16'(len)});
                for (int k = 0; k < len; k++) begin
                    put($urandom);
                    if ($urandom_range(0, 3) == 0) cyc(1);
                end
            end
            if ($urandom_range(0, 4) == 0) cyc($urandom_range(1, 5));
        end
        drain("rand");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
